// File: rtl/ray_tracer.sv
// Iterative ray-marching collision unit: steps a point along a direction vector
// and reports the colour of the first of two spheres it lands inside.
module ray_tracer #(
    parameter int MAX_STEPS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_bus,
    input  logic [27:0]  init,
    input  logic [30:0]  dir,
    output logic [11:0]  dout,
    output logic         collision_ret,
    output logic [79:0]  t_show,
    output logic [2:0]   min_show
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_STEP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [107:0]       r_scene;      // in_bus[127:20]: background + both objects
    logic [30:0]        r_dir;
    logic signed [12:0] r_px, r_py, r_pz;
    logic [15:0]        r_k;
    logic [15:0]        r_hit_k;
    logic [11:0]        r_dout;
    logic               r_coll;
    logic [2:0]         r_min;

    logic               w_unused_bus;
    assign w_unused_bus = ^in_bus[19:0];

    logic [11:0] w_bg;
    logic [47:0] w_obj0, w_obj1;
    assign w_bg   = r_scene[107:96];
    assign w_obj0 = r_scene[95:48];
    assign w_obj1 = r_scene[47:0];

    // Exact inside-sphere test; p is always within bounds while stepping.
    function automatic logic sphere_hit(input logic signed [12:0] px,
                                        input logic signed [12:0] py,
                                        input logic signed [12:0] pz,
                                        input logic [47:0] obj);
        logic signed [12:0] ddx, ddy, ddz;
        logic [25:0]        sx, sy, sz;
        logic [27:0]        sum;
        logic [15:0]        r2;
        ddx = px - $signed({3'b000, obj[27:18]});
        ddy = py - $signed({3'b000, obj[17:8]});
        ddz = pz - $signed({5'b00000, obj[7:0]});
        sx  = $unsigned(26'(ddx * ddx));
        sy  = $unsigned(26'(ddy * ddy));
        sz  = $unsigned(26'(ddz * ddz));
        sum = {2'b00, sx} + {2'b00, sy} + {2'b00, sz};
        r2  = {8'h00, obj[35:28]} * {8'h00, obj[35:28]};
        return (obj[35:28] != 8'd0) && (sum <= {12'h000, r2});
    endfunction

    logic               w_hit0, w_hit1, w_hit, w_oob, w_last, w_miss;
    logic signed [12:0] w_nx, w_ny, w_nz;

    assign w_hit0 = sphere_hit(r_px, r_py, r_pz, w_obj0);
    assign w_hit1 = sphere_hit(r_px, r_py, r_pz, w_obj1);

    assign w_nx = r_px + {{2{r_dir[30]}}, r_dir[30:20]};
    assign w_ny = r_py + {{2{r_dir[19]}}, r_dir[19:9]};
    assign w_nz = r_pz + {{4{r_dir[8]}}, r_dir[8:0]};

    assign w_oob  = w_nx[12] || (w_nx[11:10] != 2'b00) ||
                    w_ny[12] || (w_ny[11:10] != 2'b00) ||
                    w_nz[12] || (w_nz[11:8]  != 4'h0);
    assign w_last = (r_k == 16'(MAX_STEPS - 1));

    always_comb begin
        w_state_next = r_state;
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        case (r_state)
            S_LOAD: w_state_next = S_STEP;
            S_STEP: begin
                if (w_hit0 || w_hit1) begin
                    w_hit        = 1'b1;
                    w_state_next = S_DONE;
                end else if (w_last || w_oob) begin
                    w_miss       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_LOAD;
            default: w_state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_scene <= '0;
            r_dir   <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_pz    <= '0;
            r_k     <= '0;
            r_hit_k <= '0;
            r_dout  <= '0;
            r_coll  <= 1'b0;
            r_min   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_LOAD: begin
                    r_scene <= in_bus[127:20];
                    r_dir   <= dir;
                    r_px    <= $signed({3'b000, init[27:18]});
                    r_py    <= $signed({3'b000, init[17:8]});
                    r_pz    <= $signed({5'b00000, init[7:0]});
                    r_k     <= '0;
                end
                S_STEP: begin
                    if (w_hit) begin
                        // Object 0 takes priority when both contain the point.
                        r_dout  <= w_hit0 ? w_obj0[47:36] : w_obj1[47:36];
                        r_coll  <= 1'b1;
                        r_min   <= w_hit0 ? 3'd1 : 3'd2;
                        r_hit_k <= r_k;
                    end else begin
                        r_px <= w_nx;
                        r_py <= w_ny;
                        r_pz <= w_nz;
                        r_k  <= r_k + 16'd1;
                        if (w_miss) begin
                            r_dout  <= w_bg;
                            r_coll  <= 1'b0;
                            r_min   <= '0;
                            r_hit_k <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout          = r_dout;
    assign collision_ret = r_coll;
    assign min_show      = r_min;
    assign t_show        = {{3{r_px[12]}}, r_px, {3{r_py[12]}}, r_py,
                            {3{r_pz[12]}}, r_pz, r_k, r_hit_k};

endmodule

// File: tb/tb_ray_tracer.sv
// Self-checking bench for ray_tracer: directed scenes plus randomized traces
// compared against a plain-integer ray-marching model.
module tb_ray_tracer;

    localparam int MAX_STEPS = 32;

    logic         clk;
    logic         rst;
    logic [127:0] in_bus;
    logic [27:0]  init;
    logic [30:0]  dir;
    logic [11:0]  dout;
    logic         collision_ret;
    logic [79:0]  t_show;
    logic [2:0]   min_show;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] prev_res;   // {dout, collision_ret, min_show, t_show[15:0]}

    ray_tracer #(.MAX_STEPS(MAX_STEPS)) dut (
        .clk(clk), .rst(rst), .in_bus(in_bus), .init(init), .dir(dir),
        .dout(dout), .collision_ret(collision_ret), .t_show(t_show),
        .min_show(min_show)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] mk_obj(input logic [11:0] col, input int r,
                                           input int cx, input int cy, input int cz);
        return {col, 8'(r), 10'(cx), 10'(cy), 8'(cz)};
    endfunction

    function automatic logic [127:0] mk_bus(input logic [11:0] bg,
                                            input logic [47:0] o0, input logic [47:0] o1);
        return {bg, o0, o1, 20'h00000};
    endfunction

    function automatic logic [30:0] mk_dir(input int dx, input int dy, input int dz);
        return {11'(dx), 11'(dy), 9'(dz)};
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Walk the ray with plain ints; returns packed result and the final step index.
    task automatic model(input logic [127:0] bus, input logic [27:0] ini, input logic [30:0] dr,
                         output logic [31:0] res, output int kend);
        int px, py, pz, dx, dy, dz;
        logic [47:0] obj [2];
        obj[0] = bus[115:68];
        obj[1] = bus[67:20];
        px = int'(ini[27:18]);
        py = int'(ini[17:8]);
        pz = int'(ini[7:0]);
        dx = int'($signed(dr[30:20]));
        dy = int'($signed(dr[19:9]));
        dz = int'($signed(dr[8:0]));
        res  = '0;
        kend = MAX_STEPS - 1;
        for (int k = 0; k < MAX_STEPS; k++) begin
            for (int o = 0; o < 2; o++) begin
                int r, ex, ey, ez;
                r  = int'(obj[o][35:28]);
                ex = px - int'(obj[o][27:18]);
                ey = py - int'(obj[o][17:8]);
                ez = pz - int'(obj[o][7:0]);
                if (r != 0 && ex*ex + ey*ey + ez*ez <= r*r) begin
                    res  = {obj[o][47:36], 1'b1, 3'(o + 1), 16'(k)};
                    kend = k;
                    return;
                end
            end
            px += dx; py += dy; pz += dz;
            if (k == MAX_STEPS - 1 || px < 0 || px > 1023 || py < 0 || py > 1023 ||
                pz < 0 || pz > 255) begin
                res  = {bus[127:116], 1'b0, 3'd0, 16'd0};
                kend = k;
                return;
            end
        end
    endtask

    function automatic logic [31:0] observed();
        return {dout, collision_ret, min_show, t_show[15:0]};
    endfunction

    // Called at a negedge just before a LOAD edge; returns at the negedge after DONE.
    task automatic run_trace(input string tag, input logic [127:0] bus,
                             input logic [27:0] ini, input logic [30:0] dr);
        logic [31:0] exp_res;
        int kend;
        model(bus, ini, dr, exp_res, kend);
        in_bus = bus;
        init   = ini;
        dir    = dr;
        @(negedge clk);
        check({tag, " origin"}, {16'h0, t_show[79:16]},
              {16'h0, 6'h0, ini[27:18], 6'h0, ini[17:8], 8'h0, ini[7:0], 16'h0});
        in_bus = {$urandom, $urandom, $urandom, $urandom};
        init   = 28'($urandom);
        dir    = 31'($urandom);
        repeat (kend) @(negedge clk);
        check({tag, " before result"}, 80'(observed()), 80'(prev_res));
        @(negedge clk);
        check({tag, " result"}, 80'(observed()), 80'(exp_res));
        @(negedge clk);
        check({tag, " held"}, 80'(observed()), 80'(exp_res));
        prev_res = exp_res;
    endtask

    logic [47:0]  o_a, o_b;
    logic [127:0] scene;

    initial begin
        rst    = 1'b1;
        in_bus = '0;
        init   = '0;
        dir    = '0;
        prev_res = '0;
        repeat (2) @(negedge clk);
        check("reset outputs", {t_show, dout, collision_ret, min_show} , 96'h0 >> 16);
        check("reset t_show", t_show, 80'h0);

        rst = 1'b0;
        o_a   = mk_obj(12'hFFF, 8, 0, 32, 4);
        scene = mk_bus(12'h000, o_a, 48'h0);
        run_trace("single hit", scene, 28'h0, 31'h0000_0800);
        run_trace("dir0 miss a", scene, 28'h0, 31'h0);
        run_trace("dir0 miss b", scene, 28'h0, 31'h0);
        run_trace("dir switched", scene, 28'h0, 31'h0000_0800);

        o_b = mk_obj(12'h0F0, 8, 0, 32, 4);
        run_trace("tie obj0 wins", mk_bus(12'h123, o_a, o_b), 28'h0, 31'h0000_0800);
        run_trace("obj0 disabled", mk_bus(12'h123, mk_obj(12'hFFF, 0, 0, 32, 4), o_b),
                  28'h0, 31'h0000_0800);
        run_trace("bounds exit", mk_bus(12'hABC, 48'h0, 48'h0),
                  {10'd5, 10'd1020, 8'd3}, mk_dir(0, 8, 0));
        run_trace("origin inside", mk_bus(12'h456, o_b, o_a), {10'd0, 10'd30, 8'd5}, 31'h0);

        for (int t = 0; t < 40; t++) begin
            int ix, iy, iz, dx, dy, dz, m;
            ix = $urandom_range(0, 1023);
            iy = $urandom_range(0, 1023);
            iz = $urandom_range(0, 255);
            dx = $urandom_range(0, 16) - 8;
            dy = $urandom_range(0, 16) - 8;
            dz = $urandom_range(0, 8) - 4;
            if ($urandom_range(0, 7) == 0) begin dx = 0; dy = 0; dz = 0; end
            m   = $urandom_range(0, 40);
            o_a = mk_obj(12'($urandom), $urandom_range(0, 12),
                         clampi(ix + dx*m + $urandom_range(0, 6) - 3, 1023),
                         clampi(iy + dy*m + $urandom_range(0, 6) - 3, 1023),
                         clampi(iz + dz*m + $urandom_range(0, 6) - 3, 255));
            m   = $urandom_range(0, 40);
            o_b = mk_obj(12'($urandom), $urandom_range(0, 12),
                         clampi(ix + dx*m, 1023), clampi(iy + dy*m, 1023),
                         clampi(iz + dz*m, 255));
            run_trace($sformatf("random %0d", t), mk_bus(12'($urandom), o_a, o_b),
                      {10'(ix), 10'(iy), 8'(iz)}, mk_dir(dx, dy, dz));
        end

        rst = 1'b1;
        @(negedge clk);
        check("mid-run reset", {dout, collision_ret, min_show}, 80'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
